// File: rtl/reg_writeback.sv
// reg_writeback: merges the single-cycle ALU results and the queued LSU results
// onto the register file's single write port. It also keeps a per-register
// busy scoreboard for the decode-stage hazard logic.
module reg_writeback #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int QDEPTH = 2,
  localparam int RW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [RW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  input  logic            iss_valid,
  input  logic [RW-1:0]   iss_rd,
  output logic [NREG-1:0] busy,
  output logic            wb_stall,
  output logic            we,
  output logic [RW-1:0]   rd,
  output logic [XLEN-1:0] wd
);

  localparam int QW = $clog2(QDEPTH);
  localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

  logic [RW-1:0]   q_rd [QDEPTH];
  logic [XLEN-1:0] q_wd [QDEPTH];
  logic [QW-1:0]   wr_ptr;
  logic [QW-1:0]   rd_ptr;
  logic [QW:0]     count;

  logic            push;
  logic            pop;
  logic            sel_valid;
  logic [RW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_wd;
  logic [NREG-1:0] busy_next;

  // Ready/stall come only from the registered count, so a same-cycle pop
  // never opens a slot for the producer.
  assign lsu_ready = !rst && (count != QFULL);
  assign wb_stall  = (count == QFULL);
  assign push      = lsu_valid && lsu_ready;
  // The ALU always wins; the queue drains only in ALU-idle cycles.
  assign pop       = !alu_valid && (count != '0);

  // Pick the write candidate for this cycle: the ALU first, then the queue head.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_wd    = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_wd    = alu_wd;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = q_rd[rd_ptr];
      sel_wd    = q_wd[rd_ptr];
    end
  end

  // Queue pointers and occupancy. Reset discards whatever was queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage. It needs no reset because the pointers alone say which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr] <= lsu_rd;
      q_wd[wr_ptr] <= lsu_wd;
    end
  end

  // Registered write port. An x0 destination is consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      rd <= '0;
      wd <= '0;
    end else begin
      we <= sel_valid && (sel_rd != '0);
      if (sel_valid && (sel_rd != '0)) begin
        rd <= sel_rd;
        wd <= sel_wd;
      end
    end
  end

  // Scoreboard next state. The clear comes from the write being captured now.
  // A new issue to the same register overrides that clear. x0 is never busy.
  always_comb begin
    busy_next = busy;
    if (we) busy_next[rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback. Each stimulus step pushes the write it
// should produce into a queue. A negedge monitor pops one entry from that
// queue for every write the DUT emits.
module tb_reg_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [31:0] busy;
  logic        wb_stall;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q [$];

  reg_writeback #(.XLEN(32), .NREG(32), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy(busy), .wb_stall(wb_stall),
    .we(we), .rd(rd), .wd(wd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic alu(input logic [4:0] r, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = r; alu_wd = d;
  endtask

  task automatic lsu(input logic [4:0] r, input logic [31:0] d);
    lsu_valid = 1'b1; lsu_rd = r; lsu_wd = d;
  endtask

  task automatic iss(input logic [4:0] r);
    iss_valid = 1'b1; iss_rd = r;
  endtask

  // Monitor: every emitted write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got rd=%0d wd=%0h want none", rd, wd);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_stream", {27'd0, rd, wd}, {27'd0, e});
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    lsu(5'd9, 32'h99);

    // Reset: a producer that is offering data must not be accepted.
    tick();
    tick();
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_ready", lsu_ready, 1);
    chk("post_rst_stall", wb_stall, 0);
    tick();
    chk("post_rst_no_push_we", we, 0);
    tick();
    chk("post_rst_no_push_we2", we, 0);

    // ALU path with scoreboard.
    iss(5'd5);
    tick(); idle();
    chk("alu_busy5_n1", busy[5], 1);
    tick();
    alu(5'd5, 32'hDEADBEEF); exp_q.push_back({5'd5, 32'hDEADBEEF});
    chk("alu_busy5_n2", busy[5], 1);
    tick(); idle();
    chk("alu_we_n3", we, 1);
    chk("alu_rd_n3", rd, 5);
    chk("alu_wd_n3", wd, 32'hDEADBEEF);
    chk("alu_busy5_n3", busy[5], 1);
    tick();
    chk("alu_busy5_n4", busy[5], 0);
    chk("alu_we_n4", we, 0);

    // Conflict: the ALU goes first and the LSU result follows one cycle later.
    alu(5'd3, 32'h11); lsu(5'd7, 32'h22);
    exp_q.push_back({5'd3, 32'h11});
    exp_q.push_back({5'd7, 32'h22});
    tick(); idle();
    chk("conf_rd_first", rd, 3);
    tick();
    chk("conf_we_second", we, 1);
    chk("conf_rd_second", rd, 7);
    tick();
    chk("conf_we_idle", we, 0);

    // Full queue while the ALU hogs the port.
    alu(5'd10, 32'hA0); lsu(5'd8, 32'h80); exp_q.push_back({5'd10, 32'hA0});
    tick();
    chk("fill_ready_one", lsu_ready, 1);
    alu(5'd11, 32'hB0); lsu(5'd9, 32'h90); exp_q.push_back({5'd11, 32'hB0});
    tick();
    chk("full_ready", lsu_ready, 0);
    chk("full_stall", wb_stall, 1);
    alu(5'd13, 32'hD0); lsu(5'd12, 32'hC0); exp_q.push_back({5'd13, 32'hD0});
    tick();
    chk("full_hold_ready", lsu_ready, 0);
    chk("full_hold_stall", wb_stall, 1);
    idle();
    exp_q.push_back({5'd8, 32'h80});
    exp_q.push_back({5'd9, 32'h90});
    tick();
    chk("drain_rd8", rd, 8);
    chk("drain_ready", lsu_ready, 1);
    chk("drain_stall", wb_stall, 0);
    tick();
    chk("drain_rd9", rd, 9);
    chk("drain_we9", we, 1);
    tick();
    chk("drain_idle_we", we, 0);

    // x0 handling.
    alu(5'd0, 32'hFFFFFFFF); iss(5'd0);
    tick(); idle();
    chk("x0_alu_we", we, 0);
    chk("x0_busy", busy, 0);
    lsu(5'd0, 32'h55);
    tick(); idle();
    tick();
    chk("x0_lsu_we", we, 0);
    tick();
    chk("x0_lsu_we2", we, 0);
    // If the x0 entry were left in the queue, one more push would fill it.
    alu(5'd1, 32'h01); lsu(5'd6, 32'h66); exp_q.push_back({5'd1, 32'h01});
    tick();
    chk("x0_popped_stall", wb_stall, 0);
    alu(5'd2, 32'h02); lsu(5'd14, 32'hE0); exp_q.push_back({5'd2, 32'h02});
    tick();
    chk("refill_stall", wb_stall, 1);
    idle();
    exp_q.push_back({5'd6, 32'h66});
    exp_q.push_back({5'd14, 32'hE0});
    tick(); tick(); tick();
    chk("refill_done_we", we, 0);

    // A set and a clear of the same register on one edge: the set wins.
    alu(5'd4, 32'h44); iss(5'd4); exp_q.push_back({5'd4, 32'h44});
    tick(); idle();
    chk("sc_we4", we, 1);
    chk("sc_busy4_pre", busy[4], 1);
    iss(5'd4);
    tick(); idle();
    chk("sc_busy4_kept", busy[4], 1);
    alu(5'd4, 32'h45); exp_q.push_back({5'd4, 32'h45});
    tick(); idle();
    tick();
    chk("sc_busy4_cleared", busy[4], 0);

    // Reset mid-stream with one entry queued and one selected result.
    alu(5'd21, 32'h21); lsu(5'd22, 32'h22); iss(5'd25);
    exp_q.push_back({5'd21, 32'h21});
    tick(); idle();
    chk("mid_busy25", busy[25], 1);
    rst = 1'b1;
    alu(5'd23, 32'h23);
    tick();
    chk("mid_rst_we", we, 0);
    chk("mid_rst_ready", lsu_ready, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    idle();
    tick();
    chk("mid_post_we", we, 0);
    chk("mid_post_ready", lsu_ready, 1);
    chk("mid_post_stall", wb_stall, 0);
    tick();
    chk("mid_post_we2", we, 0);
    tick();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side front end of the integer register file: merges results from the single-cycle ALU pipe and the variable-latency load/store unit (LSU) onto the register file's one write port. Tracks which architectural registers have a write in flight (scoreboard) for the decode-stage hazard logic. Sits between the execute/memory stages and the register file's we/rd/wd inputs.

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers; index width is log2(NREG)
- QDEPTH, 2, LSU result queue depth (power of two, >= 2)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- alu_valid  in  1  ALU result present this cycle; cannot be back-pressured
- alu_rd  in  5  ALU destination register
- alu_wd  in  XLEN  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  queue can accept; transfer when lsu_valid && lsu_ready
- lsu_rd  in  5  LSU destination register
- lsu_wd  in  XLEN  LSU result
- iss_valid  in  1  instruction issued with a register destination
- iss_rd  in  5  destination of issued instruction
- busy  out  NREG  per-register write-pending bits
- wb_stall  out  1  queue full; upstream must bubble the ALU pipe
- we  out  1  register file write enable (registered)
- rd  out  5  register file write address (registered)
- wd  out  XLEN  register file write data (registered)

## Operation
- LSU queue: FIFO, QDEPTH entries of {rd, wd}; push on lsu_valid && lsu_ready; in-order pop.
- lsu_ready = !rst && (count != QDEPTH); no dependence on same-cycle pop.
- wb_stall = (count == QDEPTH).
- Arbitration each cycle, fixed priority:
  - alu_valid: select ALU result; queue not popped.
  - else queue non-empty: select and pop head.
  - else: nothing selected.
- Selected entry with rd == 0: consumed (popped if from queue), we stays 0.
- Selected entry with rd != 0: next cycle we=1, rd, wd = entry.
- Push and pop in same cycle: both occur; count unchanged; a push into an empty queue cannot pop in the same cycle.
- Scoreboard:
  - iss_valid && iss_rd != 0: busy[iss_rd] set at next edge.
  - we == 1: busy[rd] cleared at the edge on which the register file captures the write.
  - Set and clear of same register at same edge: set wins.
  - busy[0] constant 0.
  - Single bit per register; a second issue to an already-busy register is an upstream protocol violation (WAW stall upstream); the block takes no special action.
- Reset: queue emptied (contents discarded), busy = 0, we = 0, rd = 0, wd = 0, lsu_ready = 0 while rst is high. Reset mid-operation discards queued and selected results; no write emitted the cycle after reset.

## Timing
- ALU result at cycle N: we/rd/wd valid in cycle N+1; register file written at end of N+1; busy bit clear visible in N+2.
- LSU accepted at N into empty queue with no ALU traffic in N+1: selected N+1, write visible N+2.
- Each ALU-valid cycle delays queued LSU results by one cycle; no starvation bound beyond upstream honouring wb_stall.
- First cycle after rst deasserts: lsu_ready = 1, wb_stall = 0.
- All outputs except lsu_ready and wb_stall are registered; those two derive combinationally from the registered count and rst.

## Test plan
- Reset: assert rst 2 cycles with lsu_valid=1 -> lsu_ready=0, we=0, busy=0; first cycle after release lsu_ready=1, no push occurred in reset.
- ALU path: iss rd=5 at N, alu_valid rd=5 wd=0xDEADBEEF at N+2 -> busy[5]=1 from N+1; we=1 rd=5 wd=0xDEADBEEF at N+3; busy[5]=0 at N+4.
- Conflict: alu rd=3 wd=0x11 and lsu rd=7 wd=0x22 both at N -> write (3,0x11) at N+1, (7,0x22) at N+2.
- Full queue: alu_valid held high, push LSU rd=8 then rd=9 -> lsu_ready=0, wb_stall=1; drop alu_valid -> writes rd=8 then rd=9 in consecutive cycles, lsu_ready returns 1 after first pop.
- x0: alu rd=0 wd=0xFFFFFFFF -> we stays 0; iss rd=0 -> busy[0]=0; lsu rd=0 popped with no write.
- Edge cases: iss rd=4 in the cycle we=1 rd=4 -> busy[4] remains 1; rst mid-stream with 1 queued entry -> queue empty, no write emitted after reset.
